// File: rtl/rx_pac_align.sv
// rx_pac_align: strips preamble/SFD from a GMII-style byte stream and decodes sync packets.
// Build with RX_PAC_ALIGN_STAT_EN defined to enable the PKT_CNT / ERR_CNT statistics.
module rx_pac_align #(
    parameter int unsigned PRE_MIN   = 2,
    parameter int unsigned MAX_LEN   = 2047,
    parameter logic [7:0]  SYNC_TYPE = 8'h01,
    parameter logic [23:0] TMO_CYC   = 24'd2500000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  PHY_RXD,
    input  logic        PHY_RX_DV,
    input  logic        PHY_RX_ER,
    output logic [7:0]  PA_RXD,
    output logic        PA_RX_DV,
    output logic        PA_RX_ER,
    output logic        PA_PAC_STP,
    output logic        PA_VP,
    output logic        PA_RX50HZ,
    output logic        PA_RX_OK,
    output logic [15:0] PKT_CNT,
    output logic [15:0] ERR_CNT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    logic [1:0]    state;
    logic [2:0]    pre_cnt;
    logic [LW-1:0] len;
    logic          ovf;
    logic          pkt_err;
    logic [7:0]    byte0;
    logic          byte1_b0;
    logic [23:0]   wd_cnt;

    logic sfd_ok;
    logic fwd;
    logic pkt_end;
    logic sync_hit;

    assign sfd_ok   = (PHY_RXD == SFD_BYTE) && (pre_cnt >= 3'(PRE_MIN));
    assign fwd      = (state == ST_DATA) && PHY_RX_DV && (len != LEN_MAX);
    assign pkt_end  = (state == ST_DATA) && !PHY_RX_DV;
    assign sync_hit = pkt_end && (byte0 == SYNC_TYPE)
                      && (len > LW'(1)) && !pkt_err;

    // Framing FSM: preamble count, payload length, sticky error flags, sync bytes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            pre_cnt  <= '0;
            len      <= '0;
            ovf      <= 1'b0;
            pkt_err  <= 1'b0;
            byte0    <= '0;
            byte1_b0 <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (PHY_RX_DV) begin
                        if (PHY_RXD == PRE_BYTE) begin
                            state   <= ST_PRE;
                            pre_cnt <= 3'd1;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_PRE: begin
                    if (!PHY_RX_DV) begin
                        state <= ST_IDLE;
                    end else if (PHY_RXD == PRE_BYTE) begin
                        if (pre_cnt != 3'd7)
                            pre_cnt <= pre_cnt + 3'd1;
                    end else if (sfd_ok) begin
                        state   <= ST_DATA;
                        len     <= '0;
                        ovf     <= 1'b0;
                        pkt_err <= 1'b0;
                    end else begin
                        state <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (!PHY_RX_DV) begin
                        state <= ST_IDLE;
                    end else begin
                        if (len == LEN_MAX) begin
                            ovf     <= 1'b1;
                            pkt_err <= 1'b1;
                        end else begin
                            len <= len + LW'(1);
                        end
                        if (PHY_RX_ER)
                            pkt_err <= 1'b1;
                        if (len == '0)
                            byte0 <= PHY_RXD;
                        if (len == LW'(1))
                            byte1_b0 <= PHY_RXD[0];
                    end
                end
                ST_DROP: begin
                    if (!PHY_RX_DV)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Payload and strobes registered one cycle behind the PHY
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PA_RXD     <= '0;
            PA_RX_DV   <= 1'b0;
            PA_RX_ER   <= 1'b0;
            PA_PAC_STP <= 1'b0;
            PA_VP      <= 1'b0;
            PA_RX50HZ  <= 1'b0;
        end else begin
            PA_RXD     <= fwd ? PHY_RXD : 8'h00;
            PA_RX_DV   <= fwd;
            PA_RX_ER   <= (fwd && PHY_RX_ER) || (pkt_end && ovf);
            PA_PAC_STP <= pkt_end;
            PA_VP      <= sync_hit;
            if (sync_hit)
                PA_RX50HZ <= byte1_b0;
        end
    end

    // Link watchdog: cleared by each sync pulse, saturates at the timeout
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            wd_cnt <= TMO_CYC;
        else if (PA_VP)
            wd_cnt <= '0;
        else if (wd_cnt < TMO_CYC)
            wd_cnt <= wd_cnt + 24'd1;
    end

    assign PA_RX_OK = (wd_cnt < TMO_CYC);

`ifdef RX_PAC_ALIGN_STAT_EN
    logic        drop_pre;
    logic        err_inc;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;

    assign drop_pre = (state == ST_PRE) && PHY_RX_DV
                      && (PHY_RXD != PRE_BYTE) && !sfd_ok;
    assign err_inc  = (pkt_end && pkt_err) || drop_pre;

    // Saturating good/bad packet counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (pkt_end && !pkt_err && pkt_cnt != 16'hFFFF)
                pkt_cnt <= pkt_cnt + 16'd1;
            if (err_inc && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

    assign PKT_CNT = pkt_cnt;
    assign ERR_CNT = err_cnt;
`else
    assign PKT_CNT = 16'h0000;
    assign ERR_CNT = 16'h0000;
`endif

endmodule

// File: doc/rx_pac_align.md
Name: rx_pac_align

Overview:
Receive-side packet aligner between the PHY receive interface (8-bit, GMII-style byte stream) and the receive control decoder stage.
- Detects preamble (0x55) and SFD (0xD5), strips them, and forwards payload bytes with valid, error and end-of-packet strobes.
- Decodes sync packets into a vertical-pulse strobe and a 50 Hz flag.
- Keeps a link watchdog that produces the receive-OK level consumed downstream.

Parameters:
PRE_MIN, 2, minimum count of 0x55 bytes before SFD for a valid start (1..7)
MAX_LEN, 2047, maximum payload bytes forwarded per packet
SYNC_TYPE, 8'h01, first-payload-byte value identifying a sync packet
TMO_CYC, 24'd2500000, watchdog timeout in CLK cycles without a good sync packet

Ports:
CLK  in  1  system clock, all logic rising-edge
RST  in  1  asynchronous active-high reset
PHY_RXD  in  8  PHY receive byte
PHY_RX_DV  in  1  PHY receive data valid
PHY_RX_ER  in  1  PHY receive error
PA_RXD  out  8  aligned payload byte
PA_RX_DV  out  1  payload byte valid
PA_RX_ER  out  1  error flag aligned with PA_RXD, or with PA_PAC_STP on length overflow
PA_PAC_STP  out  1  one-cycle end-of-packet pulse
PA_VP  out  1  one-cycle pulse, good sync packet received
PA_RX50HZ  out  1  50 Hz mode flag from last good sync packet
PA_RX_OK  out  1  link-good level
PKT_CNT  out  16  good packet counter (optional feature)
ERR_CNT  out  16  bad packet counter (optional feature)

Behaviour:
- Reset (async, RST=1): every output 0, state IDLE, all counters 0, watchdog expired. Reset mid-packet drops the packet; no PA_PAC_STP is issued for it.
- FSM states: IDLE, PRE, DATA, DROP.
  - IDLE:
    - DV=1 and RXD=0x55: go to PRE, pre_cnt=1.
    - DV=1 and any other byte: go to DROP.
  - PRE:
    - DV=0: go to IDLE, no strobes.
    - 0x55: pre_cnt+1, saturating at 7.
    - 0xD5 with pre_cnt>=PRE_MIN: go to DATA, len=0.
    - Anything else, or SFD too early: go to DROP.
  - DATA:
    - While DV=1, each byte is registered to PA_RXD/PA_RX_DV with exactly 1 cycle latency. PHY_RX_ER is registered alongside onto PA_RX_ER and sets a sticky pkt_err.
    - len increments per byte. Bytes beyond MAX_LEN are discarded (PA_RX_DV=0) and set sticky ovf and pkt_err.
    - On the first cycle with DV=0: go to IDLE, and in the next cycle pulse PA_PAC_STP for 1 cycle, with PA_RX_ER=ovf during that pulse.
  - DROP: no outputs. Return to IDLE when DV=0.
- PHY_RX_ER outside DATA is ignored.
- Sync decode:
  - Byte 0==SYNC_TYPE, len>=2 and pkt_err=0 at end of packet: PA_VP pulses in the same cycle as PA_PAC_STP, and PA_RX50HZ loads bit 0 of payload byte 1 in that cycle.
  - Otherwise PA_VP stays 0 and PA_RX50HZ holds.
- Watchdog:
  - 24-bit counter, cleared on each PA_VP, increments otherwise, saturates at TMO_CYC.
  - PA_RX_OK=1 iff counter<TMO_CYC. It rises the cycle after the first PA_VP and falls the cycle after the counter reaches TMO_CYC.
- Back-to-back packets: DV low for a single cycle between packets is sufficient. A new preamble can start in the cycle after DV=0, while PA_PAC_STP for the previous packet is being output.

Optional Feature:
- Macro RX_PAC_ALIGN_STAT_EN.
- Defined:
  - PKT_CNT increments at each PA_PAC_STP with pkt_err=0.
  - ERR_CNT increments at each PA_PAC_STP with pkt_err=1, and at each entry to DROP from PRE.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: no counter logic; PKT_CNT and ERR_CNT are tied to 0.

Test Plan:
- Preamble 7x0x55, 0xD5, payload 01 01 AA, DV drop -> PA_RXD 01,01,AA at cycles n+1..n+3 with PA_RX_DV=1; PA_PAC_STP=PA_VP=1 one cycle; PA_RX50HZ=1; PA_RX_OK=1 next cycle.
- Preamble of 1x0x55 then 0xD5 (PRE_MIN=2) -> DROP, no PA_RX_DV, no PA_PAC_STP, ERR_CNT+1 with macro.
- Sync packet with PHY_RX_ER on byte 1 -> PA_RX_ER=1 aligned with that byte; PA_PAC_STP=1, PA_VP=0, PA_RX50HZ unchanged.
- 2050-byte payload, MAX_LEN=2047 -> exactly 2047 PA_RX_DV cycles; PA_PAC_STP with PA_RX_ER=1.
- TMO_CYC=100 after a good sync and no further packets -> PA_RX_OK falls 100 cycles after the PA_VP counter clear; the next good sync restores it.
- RST asserted mid-payload while DV stays high -> outputs 0 immediately; after release, remaining bytes go to DROP; the next packet is aligned normally.
